sd_unmux2: RTL and testbench
============================

SD_UNMUX2 -- requirements
Module: sd_unmux2

Interface
REQ-001 Parameter width, default 8: full output token width in bits; SHALL be even and >= 2.
REQ-002 Parameter adj_bits, default 1: 1 = halves are bit-interleaved, 0 = halves are MSB-half then LSB-half.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 c_srdy  input  1  consumer side: half-token valid.
REQ-006 c_drdy  output  1  consumer side: half-token accepted when c_srdy & c_drdy.
REQ-007 c_data  input  width/2  half-token data, first half then second half.
REQ-008 p_srdy  output  1  producer side: reassembled token valid.
REQ-009 p_drdy  input  1  producer side: downstream ready; transfer on p_srdy & p_drdy.
REQ-010 p_data  output  width  reassembled full token.

Function
REQ-011 The block SHALL reassemble two consecutive accepted half-tokens into one full token, with the first accepted half being the "first" half.
REQ-012 Internal state SHALL be: phase (s_first, s_second), a width/2 hold register for the first half, and a full-width output register with valid flag (p_srdy).
REQ-013 In s_first, c_drdy SHALL be 1, independent of p_srdy/p_drdy.
REQ-014 In s_second, c_drdy SHALL equal (!p_srdy | p_drdy).
REQ-015 s_first + accepted half: store c_data in the hold register; go to s_second.
REQ-016 s_second + accepted half: load the output register from hold + c_data; set p_srdy; go to s_first.
REQ-017 Otherwise, phase SHALL be unchanged.
REQ-018 adj_bits=0: p_data[width-1:width/2] SHALL be the first half and p_data[width/2-1:0] the second half.
REQ-019 adj_bits=1: for i in 0..width/2-1, p_data[2i+1] SHALL be first[i] and p_data[2i] SHALL be second[i].
REQ-020 p_srdy SHALL be driven only from a register.
REQ-021 p_srdy SHALL clear on the cycle after p_srdy & p_drdy, unless a new token loads on that same edge; in that case it stays 1 and p_data updates.
REQ-022 p_data SHALL remain stable while p_srdy=1 and p_drdy=0.
REQ-023 Latency: p_srdy SHALL assert on the clock edge that accepts the second half, i.e. visible the following cycle.
REQ-024 Throughput: with c_srdy=1 and p_drdy=1 continuously, one full token SHALL be produced every 2 cycles with no bubbles.
REQ-025 A first half SHALL be accepted while a previous full token is stalled in the output register; only the second half is back-pressured.
REQ-026 No combinational path SHALL exist from c_srdy or c_data to any output.

Reset
REQ-027 On reset, phase SHALL be s_first and p_srdy SHALL be 0.
REQ-028 On reset, p_data and the hold register SHALL be 0.
REQ-029 After reset, c_drdy SHALL be 1.
REQ-030 Reset mid-token (first half held) SHALL discard the held half; the next accepted half is treated as a first half.
REQ-031 Reset while p_srdy=1 SHALL drop the pending token without transfer.

Verification
REQ-032 width=8, adj_bits=0, p_drdy=1; send 0xA then 0x5 -> p_srdy=1 with p_data=0xA5 one cycle after the second accept.
REQ-033 width=8, adj_bits=1; send 0xF then 0x0 -> p_data=0xAA; send 0x0 then 0xF -> p_data=0x55.
REQ-034 p_drdy=0 with 0xA5 pending; send 0x3, 0xC:
- 0x3 is accepted and c_drdy drops to 0 while 0xC waits.
- Raise p_drdy: 0xA5 transfers, then 0xC is accepted in the same cycle.
- p_data=0x3C on the next cycle.
REQ-035 Accept 0x7, then assert reset for 1 cycle, then send 0x1, 0x2 -> a single token 0x12; 0x7 never appears.
REQ-036 Continuous c_srdy=1, p_drdy=1 over 8 random halves -> 4 tokens at a 2-cycle spacing, matching a scoreboard model in both adj_bits settings.
REQ-037 Random c_srdy and p_drdy over 10k cycles -> no token lost, duplicated or reordered; p_data stable whenever p_srdy=1 and p_drdy=0.

Source files
------------

// File: rtl/sd_unmux2.sv
// sd_unmux2: reassembles two consecutive half-width tokens into one full token.
//
// The first accepted half is held. The second accepted half is combined with it
// into a registered output token. Halves are combined MSB-half/LSB-half
// (adj_bits=0) or bit-interleaved (adj_bits=1).
//
// Parameters
//   width    full output token width in bits (even, >= 2)
//   adj_bits 1 = interleave halves bitwise, 0 = first half in the MSBs
//
// Ports
//   clk     clock, rising edge
//   reset   synchronous, active-high reset
//   c_srdy  half-token valid from upstream
//   c_drdy  half-token accepted when c_srdy & c_drdy
//   c_data  half-token data, first half then second half
//   p_srdy  reassembled token valid (registered)
//   p_drdy  downstream ready; transfer on p_srdy & p_drdy
//   p_data  reassembled token (registered)
module sd_unmux2 #(
    parameter int unsigned width    = 8,
    parameter int unsigned adj_bits = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 c_srdy,
    output logic                 c_drdy,
    input  logic [width/2-1:0]   c_data,
    output logic                 p_srdy,
    input  logic                 p_drdy,
    output logic [width-1:0]     p_data
);

    localparam int unsigned half_w = width / 2;

    localparam logic [0:0] s_first  = 1'b0;
    localparam logic [0:0] s_second = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [half_w-1:0] hold;
    logic [half_w-1:0] hold_nxt;
    logic [width-1:0]  p_data_nxt;
    logic              p_srdy_nxt;
    logic [width-1:0]  combined;
    logic              accept;

    // Full token formed from the held first half and the incoming second half.
    if (adj_bits == 0) begin : g_split
        assign combined = {hold, c_data};
    end else begin : g_interleave
        for (genvar i = 0; i < int'(half_w); i++) begin : g_bit
            assign combined[2*i+1] = hold[i];
            assign combined[2*i]   = c_data[i];
        end
    end

    // Next-state, handshake and datapath decode.
    always_comb begin
        state_nxt  = state;
        hold_nxt   = hold;
        p_data_nxt = p_data;
        p_srdy_nxt = p_srdy;
        c_drdy     = 1'b1;
        accept     = 1'b0;

        // Only the second half needs room in the output register; the
        // first half goes into the hold register and is never blocked.
        if (state == s_second) begin
            c_drdy = !p_srdy || p_drdy;
        end
        accept = c_srdy && c_drdy;

        if (p_srdy && p_drdy) begin
            p_srdy_nxt = 1'b0;
        end

        case (state)
            s_first: begin
                if (accept) begin
                    hold_nxt  = c_data;
                    state_nxt = s_second;
                end
            end
            s_second: begin
                // A load on the same edge as a transfer keeps p_srdy high.
                if (accept) begin
                    p_data_nxt = combined;
                    p_srdy_nxt = 1'b1;
                    state_nxt  = s_first;
                end
            end
            default: begin
                state_nxt = s_first;
            end
        endcase
    end

    // State, hold and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= s_first;
            hold   <= '0;
            p_data <= '0;
            p_srdy <= 1'b0;
        end else begin
            state  <= state_nxt;
            hold   <= hold_nxt;
            p_data <= p_data_nxt;
            p_srdy <= p_srdy_nxt;
        end
    end

endmodule

// File: tb/tb_sd_unmux2.sv
// tb_sd_unmux2: scoreboard bench for sd_unmux2, one instance per adj_bits setting
// sharing the same stimulus.
module tb_sd_unmux2;

    logic       clk;
    logic       reset;
    logic       c_srdy;
    logic [3:0] c_data;
    logic       p_drdy;
    logic       c_drdy0, c_drdy1;
    logic       p_srdy0, p_srdy1;
    logic [7:0] p_data0, p_data1;

    int n_checks = 0;
    int n_err    = 0;
    int n_xfer   = 0;
    int cyc      = 0;

    logic       en = 1'b0;
    logic       gap_chk = 1'b0;
    logic       have_prev = 1'b0;
    int         prev_cyc = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] prev0, prev1;

    // Reference model state
    logic       m_phase = 1'b0;
    logic [3:0] m_hold = '0;
    logic       m_full = 1'b0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    sd_unmux2 #(.width(8), .adj_bits(0)) dut0 (
        .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(c_drdy0),
        .c_data(c_data), .p_srdy(p_srdy0), .p_drdy(p_drdy), .p_data(p_data0)
    );

    sd_unmux2 #(.width(8), .adj_bits(1)) dut1 (
        .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(c_drdy1),
        .c_data(c_data), .p_srdy(p_srdy1), .p_drdy(p_drdy), .p_data(p_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] join_halves(input bit adj, input logic [3:0] f, input logic [3:0] s);
        logic [7:0] r;
        if (!adj) begin
            r = {f, s};
        end else begin
            for (int i = 0; i < 4; i++) begin
                r[2*i+1] = f[i];
                r[2*i]   = s[i];
            end
        end
        return r;
    endfunction

    function automatic logic model_cdrdy();
        return (m_phase == 1'b0) || !m_full || p_drdy;
    endfunction

    // Reference model update on each active edge.
    always @(posedge clk) begin
        logic acc;
        cyc++;
        if (reset) begin
            m_phase = 1'b0;
            m_hold  = '0;
            m_full  = 1'b0;
            q0.delete();
            q1.delete();
        end else if (en) begin
            acc = c_srdy && model_cdrdy();
            if (m_full && p_drdy) m_full = 1'b0;
            if (acc) begin
                if (m_phase == 1'b0) begin
                    m_hold  = c_data;
                    m_phase = 1'b1;
                end else begin
                    q0.push_back(join_halves(1'b0, m_hold, c_data));
                    q1.push_back(join_halves(1'b1, m_hold, c_data));
                    m_full  = 1'b1;
                    m_phase = 1'b0;
                end
            end
        end
    end

    // Output monitor: handshake, scoreboard pop and stall stability.
    always @(negedge clk) begin
        if (en) begin
            check("p_srdy0", 32'(p_srdy0), 32'(m_full));
            check("p_srdy1", 32'(p_srdy1), 32'(m_full));
            check("c_drdy0", 32'(c_drdy0), 32'(model_cdrdy()));
            check("c_drdy1", 32'(c_drdy1), 32'(model_cdrdy()));
            if (stall_prev) begin
                check("stable0", 32'(p_data0), 32'(prev0));
                check("stable1", 32'(p_data1), 32'(prev1));
            end
            stall_prev = p_srdy0 && !p_drdy && !reset;
            prev0 = p_data0;
            prev1 = p_data1;
            if (!reset && p_srdy0 && p_drdy) begin
                n_xfer++;
                if (q0.size() == 0) begin
                    check("sb_empty", 32'(q0.size()), 32'd1);
                end else begin
                    check("sb_data0", 32'(p_data0), 32'(q0.pop_front()));
                    check("sb_data1", 32'(p_data1), 32'(q1.pop_front()));
                end
                if (gap_chk && have_prev) check("gap", 32'(cyc - prev_cyc), 32'd2);
                prev_cyc  = cyc;
                have_prev = 1'b1;
            end
        end
    end

    // Offer one half and wait (bounded) until it is accepted.
    task automatic send_half(input logic [3:0] d);
        bit done = 0;
        c_srdy = 1'b1;
        c_data = d;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = c_drdy0;
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
        c_srdy = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int x0;
        reset  = 1'b1;
        c_srdy = 1'b0;
        c_data = '0;
        p_drdy = 1'b1;
        idle(2);
        reset = 1'b0;
        en    = 1'b1;

        // Reset values
        check("rst_p_srdy", 32'(p_srdy0), 32'd0);
        check("rst_p_data0", 32'(p_data0), 32'd0);
        check("rst_p_data1", 32'(p_data1), 32'd0);
        check("rst_c_drdy", 32'(c_drdy0), 32'd1);

        // Basic reassembly, both packings
        send_half(4'hA);
        send_half(4'h5);
        check("a5_p_srdy", 32'(p_srdy0), 32'd1);
        check("a5_split", 32'(p_data0), 32'hA5);
        check("a5_interleave", 32'(p_data1), 32'h99);

        send_half(4'hF);
        send_half(4'h0);
        check("f0_interleave", 32'(p_data1), 32'hAA);
        check("f0_split", 32'(p_data0), 32'hF0);
        send_half(4'h0);
        send_half(4'hF);
        check("0f_interleave", 32'(p_data1), 32'h55);
        idle(2);

        // Back-pressure: first half accepted while stalled, second half waits
        p_drdy = 1'b0;
        send_half(4'hA);
        send_half(4'h5);
        send_half(4'h3);
        check("bp_first_acc", 32'(p_srdy0), 32'd1);
        c_srdy = 1'b1;
        c_data = 4'hC;
        idle(2);
        check("bp_c_drdy_lo", 32'(c_drdy0), 32'd0);
        check("bp_hold_a5", 32'(p_data0), 32'hA5);
        x0 = n_xfer;
        p_drdy = 1'b1;
        #1;
        check("bp_c_drdy_hi", 32'(c_drdy0), 32'd1);
        idle(1);
        c_srdy = 1'b0;
        check("bp_xfer", 32'(n_xfer - x0), 32'd1);
        check("bp_p_srdy", 32'(p_srdy0), 32'd1);
        check("bp_3c", 32'(p_data0), 32'h3C);
        idle(2);

        // Reset mid-token discards the held half
        send_half(4'h7);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("mid_rst_p_srdy", 32'(p_srdy0), 32'd0);
        check("mid_rst_p_data", 32'(p_data0), 32'd0);
        check("mid_rst_c_drdy", 32'(c_drdy0), 32'd1);
        x0 = n_xfer;
        send_half(4'h1);
        send_half(4'h2);
        check("mid_rst_12", 32'(p_data0), 32'h12);
        idle(3);
        check("mid_rst_count", 32'(n_xfer - x0), 32'd1);

        // Reset while a token is pending drops it
        p_drdy = 1'b0;
        send_half(4'h9);
        send_half(4'h8);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("pend_rst_p_srdy", 32'(p_srdy0), 32'd0);
        p_drdy = 1'b1;
        idle(2);

        // Streaming at full rate: one token every two cycles
        x0 = n_xfer;
        gap_chk   = 1'b1;
        have_prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            c_srdy = 1'b1;
            c_data = 4'($urandom);
            idle(1);
        end
        c_srdy = 1'b0;
        idle(3);
        gap_chk = 1'b0;
        check("stream_count", 32'(n_xfer - x0), 32'd4);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            c_srdy = 1'($urandom_range(0, 1));
            c_data = 4'($urandom);
            p_drdy = 1'($urandom_range(0, 1));
            idle(1);
        end
        c_srdy = 1'b0;
        p_drdy = 1'b1;
        idle(4);
        check("drain_empty", 32'(q0.size()), 32'd0);
        check("drain_p_srdy", 32'(p_srdy0), 32'd0);

        en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
